// File: rtl/hd_stream_framer.sv
// Buffers the decoder's hard-decision word stream and re-emits it as a framed valid/ready stream.
// Optional per-frame CRC-32 trailer beat when HD_FRAME_CRC_EN is defined.
module hd_stream_framer #(
  parameter int DW          = 32,
  parameter int FRAME_WORDS = 238,
  parameter int FIFO_AW     = 4,
  parameter int FCW         = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic [DW-1:0]  m_tdata,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic           m_tlast,
  output logic [FCW-1:0] frame_cnt,
  output logic           overflow,
  input  logic           ovf_clr
);

  localparam int IW = $clog2(FRAME_WORDS + 1);

  typedef enum logic {S_ACCEPT, S_DROP} in_state_t;

  in_state_t        in_st, in_nxt;
  logic [DW:0]      mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [IW-1:0]    in_idx;
  logic [DW:0]      head;
  logic             empty, full, space, frame_end;
  logic             push, pop, drop_ovf, frame_inc;

  // Extra pointer MSB distinguishes full from empty.
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head      = mem[rd_ptr[FIFO_AW-1:0]];
  assign frame_end = in_idx == IW'(FRAME_WORDS - 1);
  assign space     = !full || pop;

  always_comb begin
    in_nxt   = in_st;
    push     = 1'b0;
    drop_ovf = 1'b0;
    if (in_valid) begin
      case (in_st)
        S_ACCEPT: begin
          if (space) push = 1'b1;
          else begin
            drop_ovf = 1'b1;
            if (!frame_end) in_nxt = S_DROP;
          end
        end
        S_DROP: begin
          // Resynchronise on the next frame-end word so the sink always sees a tlast.
          if (frame_end) begin
            if (space) begin
              push   = 1'b1;
              in_nxt = S_ACCEPT;
            end else drop_ovf = 1'b1;
          end
        end
        default: in_nxt = S_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_st     <= S_ACCEPT;
      in_idx    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_st <= in_nxt;
      if (in_valid) in_idx <= frame_end ? '0 : in_idx + IW'(1);
      if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      if (drop_ovf) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (frame_inc) frame_cnt <= frame_cnt + FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {frame_end, in_data};
  end

`ifdef HD_FRAME_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic {S_DATA, S_CRC} out_state_t;

  out_state_t  out_st, out_nxt;
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DW-1:0] d);
    logic fb;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  always_comb begin
    out_nxt   = out_st;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tlast   = 1'b0;
    pop       = 1'b0;
    frame_inc = 1'b0;
    case (out_st)
      S_DATA: begin
        m_tvalid = !empty;
        m_tdata  = empty ? '0 : head[DW-1:0];
        pop      = !empty && m_tready;
        if (pop && head[DW]) out_nxt = S_CRC;
      end
      S_CRC: begin
        m_tvalid = 1'b1;
        m_tdata  = DW'(crc_q);
        m_tlast  = 1'b1;
        if (m_tready) begin
          frame_inc = 1'b1;
          out_nxt   = S_DATA;
        end
      end
      default: out_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_st <= S_DATA;
      crc_q  <= CRC_INIT;
    end else begin
      out_st <= out_nxt;
      if (out_st == S_CRC && m_tready) crc_q <= CRC_INIT;
      else if (pop) crc_q <= crc_step(crc_q, head[DW-1:0]);
    end
  end
`else
  always_comb begin
    m_tvalid  = !empty;
    m_tdata   = empty ? '0 : head[DW-1:0];
    m_tlast   = !empty && head[DW];
    pop       = m_tvalid && m_tready;
    frame_inc = pop && head[DW];
  end
`endif

endmodule
